// File: rtl/r4abm_dot_acc.sv
// ============================================================================
// Module   : r4abm_dot_acc
// Purpose  : Streams signed 32-bit products and sums VEC_LEN of them into one
//            signed ACC_W-bit dot-product result, presented on a registered
//            valid/ready port with a sticky overflow flag.
//            Define DOT_ACC_SAT_EN to clamp the running sum on overflow
//            (default: the sum wraps modulo 2^ACC_W).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module r4abm_dot_acc #(
    parameter int VEC_LEN = 8,
    parameter int ACC_W   = 40
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_prod,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic             out_ovf
);

    localparam int                 c_CNT_W    = $clog2(VEC_LEN);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(VEC_LEN - 1);

    typedef enum logic [0:0] {
        S_ACC  = 1'b0,
        S_FULL = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ACC_W-1:0]   r_acc;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_ovf_acc;
    logic               r_out_valid;
    logic [ACC_W-1:0]   r_out_acc;
    logic               r_out_ovf;

    logic [ACC_W-1:0]   w_prod_ext;
    logic [ACC_W-1:0]   w_sum;
    logic [ACC_W-1:0]   w_acc_nxt;
    logic               w_ovf;
    logic               w_accept;
    logic               w_last;

    assign w_prod_ext = {{(ACC_W-32){in_prod[31]}}, in_prod};
    assign w_sum      = r_acc + w_prod_ext;
    // Same-sign operands whose sum flips sign.
    assign w_ovf      = (r_acc[ACC_W-1] == w_prod_ext[ACC_W-1]) &&
                        (w_sum[ACC_W-1] != r_acc[ACC_W-1]);

`ifdef DOT_ACC_SAT_EN
    // Direction of overflow follows the common operand sign.
    assign w_acc_nxt = !w_ovf          ? w_sum :
                       r_acc[ACC_W-1]  ? {1'b1, {(ACC_W-1){1'b0}}} :
                                         {1'b0, {(ACC_W-1){1'b1}}};
`else
    assign w_acc_nxt = w_sum;
`endif

    assign w_accept = in_valid && in_ready;
    assign w_last   = (r_cnt == c_CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_ACC;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        case (r_state)
            S_ACC: begin
                in_ready = !clr;
                if (in_valid && !clr && w_last) begin
                    w_state_nxt = S_FULL;
                end
            end
            S_FULL: begin
                if (out_ready) begin
                    w_state_nxt = S_ACC;
                end
            end
            default: w_state_nxt = S_ACC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc       <= '0;
            r_cnt       <= '0;
            r_ovf_acc   <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_acc   <= '0;
            r_out_ovf   <= 1'b0;
        end else if (r_state == S_ACC) begin
            if (clr) begin
                r_acc     <= '0;
                r_cnt     <= '0;
                r_ovf_acc <= 1'b0;
            end else if (w_accept) begin
                if (w_last) begin
                    r_out_acc   <= w_acc_nxt;
                    r_out_ovf   <= r_ovf_acc | w_ovf;
                    r_out_valid <= 1'b1;
                    r_acc       <= '0;
                    r_cnt       <= '0;
                    r_ovf_acc   <= 1'b0;
                end else begin
                    r_acc     <= w_acc_nxt;
                    r_cnt     <= r_cnt + 1'b1;
                    r_ovf_acc <= r_ovf_acc | w_ovf;
                end
            end
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_acc   = r_out_acc;
    assign out_ovf   = r_out_ovf;

endmodule

`default_nettype wire

// File: tb/tb_r4abm_dot_acc.sv
// ============================================================================
// Module   : tb_r4abm_dot_acc
// Purpose  : Directed self-checking bench for r4abm_dot_acc, with a 40-bit
//            and a 33-bit instance sharing the same input stream.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_r4abm_dot_acc;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr;
    logic        in_valid;
    logic [31:0] in_prod;
    logic        out_ready;

    logic        in_ready;
    logic        out_valid;
    logic [39:0] out_acc;
    logic        out_ovf;

    logic        in_ready33;
    logic        out_valid33;
    logic [32:0] out_acc33;
    logic        out_ovf33;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    r4abm_dot_acc #(.VEC_LEN(8), .ACC_W(40)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_prod   (in_prod),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_acc   (out_acc),
        .out_ovf   (out_ovf)
    );

    r4abm_dot_acc #(.VEC_LEN(8), .ACC_W(33)) u_dut33 (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready33),
        .in_prod   (in_prod),
        .out_valid (out_valid33),
        .out_ready (out_ready),
        .out_acc   (out_acc33),
        .out_ovf   (out_ovf33)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // One accepted beat; returns at posedge+1 so the next beat is back-to-back.
    task automatic beat(input logic [31:0] p);
        in_valid = 1'b1;
        in_prod  = p;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic beats(input logic [31:0] p, input int n);
        for (int i = 0; i < n; i++) beat(p);
    endtask

    // Result cycle then the single bubble cycle (out_ready assumed high).
    task automatic drain(input string tag);
        @(posedge clk);
        #1;
        check({tag, "_valid_drop"}, 64'(out_valid), 64'd0);
        check({tag, "_ready_back"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        rst       = 1'b1;
        clr       = 1'b0;
        in_valid  = 1'b0;
        in_prod   = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_acc",   64'(out_acc),   64'd0);
        check("rst_out_ovf",   64'(out_ovf),   64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd1);

        // 1: eight beats of 100
        beats(32'h0000_0064, 7);
        check("t1_valid_early", 64'(out_valid), 64'd0);
        beat(32'h0000_0064);
        check("t1_valid",    64'(out_valid), 64'd1);
        check("t1_acc",      64'(out_acc),   64'd800);
        check("t1_ovf",      64'(out_ovf),   64'd0);
        check("t1_in_ready", 64'(in_ready),  64'd0);
        drain("t1");

        // 2: -100/+100 interleaved
        for (int i = 0; i < 4; i++) begin
            beat(32'hFFFF_FF9C);
            beat(32'h0000_0064);
        end
        check("t2_valid", 64'(out_valid), 64'd1);
        check("t2_acc",   64'(out_acc),   64'd0);
        check("t2_ovf",   64'(out_ovf),   64'd0);
        drain("t2");

        // 3: backpressure for 5 cycles while a stray beat is offered
        out_ready = 1'b0;
        beats(32'h0000_0005, 8);
        in_valid = 1'b1;
        in_prod  = 32'd1000;
        for (int i = 0; i < 5; i++) begin
            check("t3_hold_valid", 64'(out_valid), 64'd1);
            check("t3_hold_acc",   64'(out_acc),   64'd40);
            check("t3_hold_ready", 64'(in_ready),  64'd0);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("t3_valid_drop", 64'(out_valid), 64'd0);
        check("t3_ready_back", 64'(in_ready),  64'd1);

        // 4: clr after three beats, clr beats in_valid
        beats(32'd7, 3);
        clr      = 1'b1;
        in_valid = 1'b1;
        in_prod  = 32'd7;
        #1;
        check("t4_clr_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        clr      = 1'b0;
        in_valid = 1'b0;
        beats(32'd1, 7);
        check("t4_valid_early", 64'(out_valid), 64'd0);
        beat(32'd1);
        check("t4_valid", 64'(out_valid), 64'd1);
        check("t4_acc",   64'(out_acc),   64'd8);
        drain("t4");

        // 5: positive overflow on the 33-bit instance
        beats(32'h4000_0000, 8);
        check("t5_valid33", 64'(out_valid33), 64'd1);
        check("t5_ovf33",   64'(out_ovf33),   64'd1);
`ifdef DOT_ACC_SAT_EN
        check("t5_acc33",   64'(out_acc33),   64'h0_FFFF_FFFF);
`else
        check("t5_acc33",   64'(out_acc33),   64'h0);
`endif
        check("t5_acc40",   64'(out_acc),     64'h02_0000_0000);
        check("t5_ovf40",   64'(out_ovf),     64'd0);
        drain("t5");

        // 5b: negative overflow; -2^32 itself is representable, beat 5 is not
        beats(32'hC000_0000, 8);
        check("t5n_ovf33", 64'(out_ovf33), 64'd1);
`ifdef DOT_ACC_SAT_EN
        check("t5n_acc33", 64'(out_acc33), 64'h1_0000_0000);
`else
        check("t5n_acc33", 64'(out_acc33), 64'h0);
`endif
        check("t5n_acc40", 64'(out_acc),   64'hFE_0000_0000);
        check("t5n_ovf40", 64'(out_ovf),   64'd0);
        drain("t5n");

        // 6: rst mid-vector discards the partial sum, even with a beat offered
        beats(32'd3, 5);
        rst      = 1'b1;
        in_valid = 1'b1;
        in_prod  = 32'd3;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        check("t6_rst_valid", 64'(out_valid), 64'd0);
        check("t6_rst_ready", 64'(in_ready),  64'd1);
        beats(32'd2, 8);
        check("t6_valid", 64'(out_valid), 64'd1);
        check("t6_acc",   64'(out_acc),   64'd16);
        check("t6_ovf",   64'(out_ovf),   64'd0);
        drain("t6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
